// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder: a linear chain of full-adder cells with an optional
// output register. Baseline architecture for adder latency/width comparisons.

module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co,
    output logic p
);

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

module ripple_carry_adder #(
    parameter int N       = 4,
    parameter bit REG_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic [N-1:0] P
);

    // c[i] is the carry into bit i; c[N] leaves the chain as Cout only.
    logic [N:0]   c;
    logic [N-1:0] s_comb;
    logic [N-1:0] p_comb;

    assign c[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        rca_full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (s_comb[i]),
            .co (c[i+1]),
            .p  (p_comb[i])
        );
    end

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            if (rst) begin
                S    <= '0;
                Cout <= 1'b0;
                P    <= '0;
            end else begin
                S    <= s_comb;
                Cout <= c[N];
                P    <= p_comb;
            end
        end
    end else begin : g_comb
        // Clock and reset have no function when the chain drives the outputs directly.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign S    = s_comb;
        assign Cout = c[N];
        assign P    = p_comb;
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed checks of ripple_carry_adder at N=1,4,8,16 (registered) and a seeded
// random sweep at N=32 (combinational).

module tb_ripple_carry_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // N=4 registered
    logic [3:0]  a4 = '0, b4 = '0, s4, p4;
    logic        cin4 = 1'b0, cout4;
    // N=8 registered
    logic [7:0]  a8 = '0, b8 = '0, s8, p8;
    logic        cin8 = 1'b0, cout8;
    // N=1 registered
    logic [0:0]  a1 = '0, b1 = '0, s1, p1;
    logic        cin1 = 1'b0, cout1;
    // N=16 registered
    logic [15:0] a16 = '0, b16 = '0, s16, p16;
    logic        cin16 = 1'b0, cout16;
    // N=32 combinational
    logic [31:0] a32 = '0, b32 = '0, s32, p32;
    logic        cin32 = 1'b0, cout32;

    ripple_carry_adder #(.N(4), .REG_OUT(1'b1)) u_dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(cin4), .S(s4), .Cout(cout4), .P(p4));
    ripple_carry_adder #(.N(8), .REG_OUT(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8), .S(s8), .Cout(cout8), .P(p8));
    ripple_carry_adder #(.N(1), .REG_OUT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .S(s1), .Cout(cout1), .P(p1));
    ripple_carry_adder #(.N(16), .REG_OUT(1'b1)) u_dut16 (
        .clk(clk), .rst(rst), .A(a16), .B(b16), .Cin(cin16), .S(s16), .Cout(cout16), .P(p16));
    ripple_carry_adder #(.N(32), .REG_OUT(1'b0)) u_dut32 (
        .clk(clk), .rst(rst), .A(a32), .B(b32), .Cin(cin32), .S(s32), .Cout(cout32), .P(p32));

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge, away from the sampling instant.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {Cout,S,P} for N=1, indexed by {A,B,Cin}; hand-derived truth table.
    logic [2:0] fa_table [8] = '{3'b000, 3'b010, 3'b011, 3'b101,
                                 3'b011, 3'b101, 3'b100, 3'b110};

    logic [16:0] exp16;
    logic [15:0] exp_p16;
    logic [32:0] exp33;

    initial begin
        // ---------------- N=4 reset and full-chain ripple ----------------
        rst = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("n4_rst_s", s4, 4'h0);
            check("n4_rst_cout", cout4, 1'b0);
            check("n4_rst_p", p4, 4'h0);
        end
        rst = 1'b0;
        tick();
        check("n4_release_s", s4, 4'hF);
        check("n4_release_cout", cout4, 1'b1);
        check("n4_release_p", p4, 4'h0);

        a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
        #1;
        check("n4_latency_hold_s", s4, 4'hF);
        check("n4_latency_hold_p", p4, 4'h0);
        tick();
        check("n4_ripple_s", s4, 4'h0);
        check("n4_ripple_cout", cout4, 1'b1);
        check("n4_ripple_p", p4, 4'hF);

        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        tick();
        check("n4_zero_s", s4, 4'h0);
        check("n4_zero_cout", cout4, 1'b0);
        check("n4_zero_p", p4, 4'h0);

        // ---------------- N=8 back-to-back ----------------
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        tick();
        check("n8_v0_s", s8, 8'h46);
        check("n8_v0_cout", cout8, 1'b0);
        check("n8_v0_p", p8, 8'h26);
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
        tick();
        check("n8_v1_s", s8, 8'h00);
        check("n8_v1_cout", cout8, 1'b1);
        check("n8_v1_p", p8, 8'hFE);

        // ---------------- N=1 exhaustive ----------------
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            a1 = abc[2]; b1 = abc[1]; cin1 = abc[0];
            tick();
            check($sformatf("n1_%0d_cout", i), cout1, fa_table[i][2]);
            check($sformatf("n1_%0d_s", i), s1, fa_table[i][1]);
            check($sformatf("n1_%0d_p", i), p1, fa_table[i][0]);
        end

        // ---------------- N=16 reset mid-stream ----------------
        void'($urandom(42));
        for (int k = 0; k < 4; k++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(0, 1));
            exp16   = {1'b0, a16} + {1'b0, b16} + 17'(cin16);
            exp_p16 = a16 ^ b16;
            tick();
            check("n16_stream_sum", {cout16, s16}, exp16);
            check("n16_stream_p", p16, exp_p16);
        end
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b1;
        rst = 1'b1;
        tick();
        check("n16_rst_drop_sum", {cout16, s16}, 17'h0);
        check("n16_rst_drop_p", p16, 16'h0);
        rst = 1'b0;
        a16 = 16'hA5A5; b16 = 16'h5A5B; cin16 = 1'b0;
        tick();
        check("n16_after_rst_sum", {cout16, s16}, 17'h10000);
        check("n16_after_rst_p", p16, 16'hFFFE);

        // ---------------- N=32 combinational random sweep ----------------
        void'($urandom(42));
        for (int k = 0; k < 100000; k++) begin
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom_range(0, 1));
            #1;
            exp33 = {1'b0, a32} + {1'b0, b32} + 33'(cin32);
            check("n32_sum", {cout32, s32}, exp33);
            check("n32_p", p32, a32 ^ b32);
        end
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; cin32 = 1'b1;
        #1;
        check("n32_max_sum", {cout32, s32}, 33'h1_FFFF_FFFF);
        check("n32_max_p", p32, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
- N-bit ripple-carry adder built from a chain of N single-bit full-adder cells; carry enters at bit 0 and ripples to bit N-1.
- Produces sum, carry-out and the per-bit propagate vector.
- Results are captured in an output register clocked by clk with synchronous active-high reset; a parameter allows combinational bypass.
- Serves as the baseline adder for latency and width characterisation against other adder architectures, for widths 1..32.

Parameters:
- N, 4, operand width in bits; legal range 1..32 (must work at N=1).
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs driven combinationally from the ripple chain (clk/rst unused).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  N  operand A, unsigned.
- B  input  N  operand B, unsigned.
- Cin  input  1  carry into bit 0.
- S  output  N  sum bits.
- Cout  output  1  carry out of bit N-1.
- P  output  N  propagate vector, P[i] = A[i] XOR B[i].

Behaviour:
- Structure: bit i is a full adder.
  - s[i] = A[i]^B[i]^c[i]
  - c[i+1] = (A[i]&B[i]) | (c[i]&(A[i]^B[i]))
  - c[0] = Cin; Cout = c[N].
  - No carry lookahead or skip logic; the critical path is strictly linear in N.
- Arithmetic: {Cout,S} == A + B + Cin, computed at N+1 bits. No overflow is possible.
  - Max result is 2^(N+1)-1, when A = B = all-ones and Cin = 1.
- P is independent of Cin and of the carry chain; it is the XOR of operands only.
- REG_OUT=1:
  - On each rising clk with rst=0, the register loads {Cout,S,P} from the current combinational values.
  - Outputs reflect inputs sampled at the previous edge. Latency is exactly 1 cycle; throughput is 1 add per cycle.
  - Inputs are sampled every cycle; there is no enable or handshake.
- Reset (REG_OUT=1):
  - rst=1 at a rising edge forces S=0, Cout=0, P=0 on that edge, regardless of A/B/Cin.
  - Reset has priority over the data load.
  - Reset mid-stream discards the in-flight result. The first valid result appears one edge after rst deasserts, computed from inputs sampled at that edge.
  - Outputs are undefined before the first clock edge; no asynchronous behaviour.
- REG_OUT=0:
  - S, Cout, P are pure combinational functions of A, B, Cin.
  - After any input change they settle to the correct value after the ripple delay; no glitch-free guarantee is made.
- No X-propagation masking: X on any input bit may propagate X to the corresponding and higher sum bits and to Cout.
- Width edge cases:
  - N=1 degenerates to a single full adder.
  - Carry out of the MSB goes only to Cout; nothing wraps back.

Test Plan:
- N=4, REG_OUT=1, with rst=1 for 2 cycles and A=F, B=F, Cin=1 → S=0, Cout=0, P=0 while reset. On the first edge after release → S=F, Cout=1, P=0.
- N=4, full-chain ripple: A=F, B=0, Cin=1 → S=0, Cout=1, P=F, appearing exactly 1 cycle after the inputs are applied. A=0, B=0, Cin=0 → S=0, Cout=0, P=0.
- N=8, back-to-back operands:
  - cycle k: A=8'h12, B=8'h34, Cin=0 → cycle k+1: S=8'h46, Cout=0, P=8'h26.
  - cycle k+1: A=8'hFF, B=8'h01, Cin=0 → cycle k+2: S=8'h00, Cout=1, P=8'hFE.
- N=1 exhaustive: all 8 combinations of A, B, Cin → {Cout,S} matches the full-adder truth table (e.g. 1,1,1 → Cout=1, S=1, P=0).
- N=32, REG_OUT=0, 100000 random {A,B,Cin} vectors with seed 42 → after settling, {Cout,S} == A+B+Cin and P == A^B for every vector.
- N=16, REG_OUT=1: assert rst during a stream of random adds → the result due on the reset edge is dropped (outputs 0). The next result corresponds to inputs present at the first non-reset edge.
